axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- AXI4-Lite master: converts a simple command stream (read/write, address, data, strobe) into single AXI4-Lite transactions.
- Returns each completion (read data, response code) on a response stream.
- Drives an AXI4-Lite slave such as the register file from fabric logic (self-test, bring-up sequencer) without the PCIe bridge.
- One transaction in flight at a time. Includes a watchdog and a completion counter.

Parameters:
C_M_AXI_ADDR_WIDTH, 40, width of cmd_addr, M_AXI_AWADDR and M_AXI_ARADDR.
C_M_AXI_DATA_WIDTH, 32, data width; only 32 supported.
TIMEOUT_CYCLES, 1024, cycles in any bus-wait state before the timeout flag sets; 0 disables the watchdog.

Ports:
M_AXI_ACLK  in  1  clock.
M_AXI_ARESETN  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
cmd_wdata  in  32  write data.
cmd_wstrb  in  4  write strobes.
rsp_valid  out  1  completion present.
rsp_ready  in  1  completion consumed.
rsp_write  out  1  completion belongs to a write.
rsp_rdata  out  32  read data; 0 for writes.
rsp_resp  out  2  BRESP or RRESP.
timeout  out  1  sticky watchdog flag.
txn_count  out  32  completed transactions, wraps.
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master ports, out/in per AXI4-Lite. Address width is C_M_AXI_ADDR_WIDTH, data 32, strobe 4, prot 3, resp 2.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction): state IDLE; all M_AXI valids/readies 0; address/data/strobe registers 0; AWPROT=ARPROT=3'b000; rsp_valid=0; rsp_* 0; timeout=0; txn_count=0; cmd_ready=0 during reset.
- All outputs are registered. No combinational path from any input to any output except cmd_ready, which equals (state==IDLE).
- States:
  - IDLE: cmd_ready=1. On cmd_valid, capture addr/data/strb.
    - Write: go to WR, with AWVALID=WVALID=1 next cycle.
    - Read: go to RD_A, with ARVALID=1 next cycle.
  - WR: AWVALID and WVALID drop independently the cycle after their own handshake; either order or the same cycle is legal. When both have completed, go to WR_B with BREADY=1.
  - WR_B: on BVALID, latch BRESP, set rsp_write=1, rsp_rdata=0, and go to RSP. BREADY drops the same edge.
  - RD_A: ARVALID held until ARREADY, then go to RD_D with RREADY=1.
  - RD_D: on RVALID, latch RDATA/RRESP, set rsp_write=0, and go to RSP.
  - RSP: rsp_valid=1, data stable until rsp_ready. On handshake, rsp_valid=0, txn_count+1 (wraps 0xFFFFFFFF->0), go to IDLE.
- Minimum latency with an always-ready slave:
  - Write: cmd handshake at cycle 0, AW/W valid at 1, BREADY at 2, BVALID at 2 gives rsp_valid at 3.
  - Read: cmd at 0, ARVALID at 1, RREADY at 2, RVALID at 2 gives rsp_valid at 3.
- VALID stability: once asserted, AWVALID/WVALID/ARVALID and their payloads do not change until accepted.
- No new command is accepted while in RSP; back-pressure on rsp stalls cmd.
- A BVALID/RVALID arriving before this block asserts the corresponding ready is ignored. It is an illegal slave behaviour, and the block must not hang on it: it waits for the legal handshake.
- Watchdog:
  - Counter clears on every state entry.
  - Increments in WR, WR_B, RD_A, RD_D.
  - At count==TIMEOUT_CYCLES, timeout sets (sticky until reset).
  - The transaction is not aborted; the protocol stays compliant.
  - Not counted in IDLE or RSP.
- cmd_wdata/cmd_wstrb are ignored for reads. Address is passed unaligned as given; alignment is the user's responsibility.

Test Plan:
- Write 0x12345678 strb 0xF to 0x8, slave always ready -> AW/W valid at cycle 1, rsp_valid at cycle 3 with rsp_write=1, rsp_resp=0, rsp_rdata=0; txn_count=1 after rsp handshake.
- Read 0x0 from the register file -> rsp_rdata=0xDEADBEEF, resp=0. Read 0x4 -> 0x76543210. Write 0xA5A5A5A5 to 0x8, then read 0x8 -> 0xA5A5A5A5.
- Slave asserts WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID stays high until its own handshake, exactly one B accepted, rsp correct.
- Slave returns RRESP=2'b10 and BRESP=2'b11 -> rsp_resp=2 and 3 respectively, data path unaffected.
- TIMEOUT_CYCLES=16, ARREADY withheld 40 cycles -> timeout=1 at the 16th RD_A cycle, ARVALID still held, read completes normally once ARREADY arrives, timeout stays 1.
- Hold rsp_ready=0 for 10 cycles with cmd_valid=1 -> cmd_ready=0 throughout, rsp stable. Assert M_AXI_ARESETN=0 during WR -> all valids 0 immediately, txn_count=0, IDLE after release.

Source files
------------

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns a simple command stream into single AXI4-Lite
// read/write transactions and returns each completion on a response stream.
// One transaction in flight; sticky watchdog flag and a completion counter.
module axil_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 40,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  // command stream
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response stream
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  // status
  output logic                            timeout,
  output logic [31:0]                     txn_count,
  // AXI4-Lite write address / data / response
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // AXI4-Lite read address / data
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int          LP_DW      = C_M_AXI_DATA_WIDTH;
  localparam int          LP_SW      = C_M_AXI_DATA_WIDTH / 8;
  localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);
  localparam bit          LP_WD_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_D, S_RSP
  } state_t;

  state_t                          r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic [LP_DW-1:0]                r_wdata;
  logic [LP_SW-1:0]                r_wstrb;
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_bready;
  logic                            r_arvalid;
  logic                            r_rready;
  logic                            r_rsp_valid;
  logic                            r_rsp_write;
  logic [LP_DW-1:0]                r_rsp_rdata;
  logic [1:0]                      r_rsp_resp;
  logic [31:0]                     r_txn_count;
  logic [31:0]                     r_wd_cnt;
  logic                            r_timeout;

  logic                            w_wr_done;
  logic                            w_leave;
  logic                            w_in_wait;
  logic                            w_wd_stay;
  logic                            w_wd_enter;
  logic [31:0]                     w_wd_inc;
  logic [31:0]                     w_wd_next;

  // A write channel counts as finished once its valid has dropped or is being accepted now.
  assign w_wr_done = (~r_awvalid | M_AXI_AWREADY) & (~r_wvalid | M_AXI_WREADY);

  // Exit condition of the current bus-wait state; early B/R beats are ignored because the ready is low.
  always_comb begin
    w_leave = 1'b0;
    case (r_state)
      S_WR:    w_leave = w_wr_done;
      S_WR_B:  w_leave = M_AXI_BVALID & r_bready;
      S_RD_A:  w_leave = M_AXI_ARREADY & r_arvalid;
      S_RD_D:  w_leave = M_AXI_RVALID & r_rready;
      default: w_leave = 1'b0;
    endcase
  end

  assign w_in_wait  = (r_state == S_WR) | (r_state == S_WR_B) |
                      (r_state == S_RD_A) | (r_state == S_RD_D);
  assign w_wd_stay  = w_in_wait & ~w_leave;
  assign w_wd_enter = ((r_state == S_IDLE) & cmd_valid) |
                      (((r_state == S_WR) | (r_state == S_RD_A)) & w_leave);
  assign w_wd_inc   = (&r_wd_cnt) ? r_wd_cnt : r_wd_cnt + 32'd1;
  // Counter holds the 1-based cycle index inside a wait state, 0 elsewhere, so timeout
  // rises in the same cycle the count reaches the limit.
  assign w_wd_next  = w_wd_stay ? w_wd_inc : (w_wd_enter ? 32'd1 : 32'd0);

  // Watchdog: restart on every state entry, flag sticks once the limit is reached.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_wd_cnt  <= 32'd0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_next;
      if (LP_WD_EN && (w_wd_next == LP_TIMEOUT))
        r_timeout <= 1'b1;
    end
  end

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state     <= S_IDLE;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_txn_count <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_A;
            end
          end
        end
        S_WR: begin
          if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
          if (w_leave) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (w_leave) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= M_AXI_BRESP;
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RD_A: begin
          if (w_leave) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_D;
          end
        end
        S_RD_D: begin
          if (w_leave) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= M_AXI_RDATA;
            r_rsp_resp  <= M_AXI_RRESP;
            r_rsp_write <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_txn_count <= r_txn_count + 32'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // cmd_ready is gated by the reset pin so it reads 0 while reset is held.
  assign cmd_ready     = (r_state == S_IDLE) & M_AXI_ARESETN;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign timeout       = r_timeout;
  assign txn_count     = r_txn_count;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: behavioural AXI4-Lite register-file slave
// with per-channel ready delays and configurable error responses.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        M_AXI_ARESETN = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [39:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout;
  logic [31:0] txn_count;
  logic [39:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;
  logic [39:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = 2'b00;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;

  axil_cmd_master #(
    .C_M_AXI_ADDR_WIDTH(40), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(M_AXI_ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .timeout(timeout), .txn_count(txn_count),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_txn  = 0;

  // slave knobs (written only by the stimulus process)
  int       aw_delay = 0;
  int       w_delay  = 0;
  int       ar_delay = 0;
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;

  // slave state (written only by the handshake monitor)
  logic [31:0] mem [16];
  logic [39:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_got, w_got, b_pending, r_pending;
  logic [31:0] r_data_q;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;

  // slave ready-delay counters (written only by the negedge driver)
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

  // per-cycle recording of DUT outputs while waiting for a response
  logic rec_awv [64];
  logic rec_wv  [64];
  logic rec_arv [64];
  logic rec_br  [64];
  logic rec_rr  [64];
  logic rec_to  [64];

  // Handshake monitor: sees pre-edge values at each rising edge, models the register file.
  always @(posedge clk) begin
    if (!M_AXI_ARESETN) begin
      aw_got = 1'b0; w_got = 1'b0; b_pending = 1'b0; r_pending = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[0] = 32'hDEADBEEF;
      mem[1] = 32'h76543210;
    end else begin
      if (M_AXI_BVALID && M_AXI_BREADY) begin b_pending = 1'b0; b_hs++; end
      if (M_AXI_RVALID && M_AXI_RREADY) r_pending = 1'b0;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_addr_q = M_AXI_AWADDR; aw_got = 1'b1; aw_hs++; end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_data_q = M_AXI_WDATA; w_strb_q = M_AXI_WSTRB; w_got = 1'b1; w_hs++;
      end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (w_strb_q[b]) mem[aw_addr_q[5:2]][8*b +: 8] = w_data_q[8*b +: 8];
        aw_got = 1'b0; w_got = 1'b0; b_pending = 1'b1;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        r_data_q = mem[M_AXI_ARADDR[5:2]]; r_pending = 1'b1; ar_hs++;
      end
    end
  end

  // Slave driver: updates its outputs on the falling edge, away from the DUT's sampling edge.
  always @(negedge clk) begin
    if (!M_AXI_ARESETN) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
      M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    end else begin
      if (M_AXI_AWVALID) begin
        M_AXI_AWREADY = (aw_cnt >= aw_delay);
        if (aw_cnt < aw_delay) aw_cnt++;
      end else begin M_AXI_AWREADY = 1'b0; aw_cnt = 0; end
      if (M_AXI_WVALID) begin
        M_AXI_WREADY = (w_cnt >= w_delay);
        if (w_cnt < w_delay) w_cnt++;
      end else begin M_AXI_WREADY = 1'b0; w_cnt = 0; end
      if (M_AXI_ARVALID) begin
        M_AXI_ARREADY = (ar_cnt >= ar_delay);
        if (ar_cnt < ar_delay) ar_cnt++;
      end else begin M_AXI_ARREADY = 1'b0; ar_cnt = 0; end
      M_AXI_BVALID = b_pending;
      M_AXI_BRESP  = bresp_cfg;
      M_AXI_RVALID = r_pending;
      M_AXI_RDATA  = r_data_q;
      M_AXI_RRESP  = rresp_cfg;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a command on a falling edge and return right after the accepting rising edge.
  task automatic issue_cmd(input logic wr, input logic [39:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin ok = 1'b1; @(posedge clk); break; end
      @(negedge clk);
    end
    check("cmd_accept", {63'd0, ok}, 64'd1);
  endtask

  // Cycle 1 is the first cycle after the command handshake; lat is the cycle rsp_valid is seen (0 = never).
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      if (k < 64) begin
        rec_awv[k] = M_AXI_AWVALID; rec_wv[k] = M_AXI_WVALID; rec_arv[k] = M_AXI_ARVALID;
        rec_br[k]  = M_AXI_BREADY;  rec_rr[k] = M_AXI_RREADY; rec_to[k]  = timeout;
      end
      if (rsp_valid) begin lat = k; break; end
    end
  endtask

  // Accept the pending response for one edge and check the counter advanced.
  task automatic consume_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_txn++;
    check({tag, "_rsp_drop"}, {63'd0, rsp_valid}, 64'd0);
    check({tag, "_txn_count"}, {32'd0, txn_count}, 64'(exp_txn));
  endtask

  task automatic do_txn(input string tag, input logic wr, input logic [39:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd, input logic [1:0] exp_resp,
                        input int exp_lat);
    int lat;
    issue_cmd(wr, a, d, s);
    wait_rsp(lat);
    $display("txn %s: %s addr=0x%0h rdata=0x%08h resp=%0d latency=%0d", tag,
             wr ? "WR" : "RD", a, rsp_rdata, rsp_resp, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_write"}, {63'd0, rsp_write}, {63'd0, wr});
    check({tag, "_rdata"}, {32'd0, rsp_rdata}, {32'd0, exp_rd});
    check({tag, "_resp"}, {62'd0, rsp_resp}, {62'd0, exp_resp});
    consume_rsp(tag);
  endtask

  initial begin
    int lat;
    int bad;
    int b0, aw0, w0;
    logic [1:0] snap_resp;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_valids", {61'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 64'd0);
    check("rst_readies", {62'd0, M_AXI_BREADY, M_AXI_RREADY}, 64'd0);
    check("rst_rsp", {62'd0, rsp_valid, timeout}, 64'd0);
    check("rst_txn", {32'd0, txn_count}, 64'd0);
    check("rst_prot", {58'd0, M_AXI_AWPROT, M_AXI_ARPROT}, 64'd0);
    M_AXI_ARESETN = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // basic write with minimum latency
    do_txn("wr8", 1'b1, 40'h8, 32'h12345678, 4'hF, 32'h0, 2'b00, 3);
    check("wr8_awv_c1", {62'd0, rec_awv[1], rec_wv[1]}, 64'd3);
    check("wr8_valid_c2", {62'd0, rec_awv[2], rec_wv[2]}, 64'd0);
    check("wr8_bready_c2", {63'd0, rec_br[2]}, 64'd1);
    check("wr8_awaddr", {24'd0, aw_addr_q}, 64'h8);

    // reads from the register file
    do_txn("rd0", 1'b0, 40'h0, 32'hFFFF_FFFF, 4'hF, 32'hDEADBEEF, 2'b00, 3);
    check("rd0_arv_c1", {63'd0, rec_arv[1]}, 64'd1);
    check("rd0_rready_c2", {63'd0, rec_rr[2]}, 64'd1);
    do_txn("rd4", 1'b0, 40'h4, 32'h0, 4'h0, 32'h76543210, 2'b00, 3);
    do_txn("rd8a", 1'b0, 40'h8, 32'h0, 4'h0, 32'h12345678, 2'b00, 3);
    do_txn("wr8b", 1'b1, 40'h8, 32'hA5A5A5A5, 4'hF, 32'h0, 2'b00, 3);
    do_txn("rd8b", 1'b0, 40'h8, 32'h0, 4'h0, 32'hA5A5A5A5, 2'b00, 3);
    do_txn("wr8s", 1'b1, 40'h8, 32'hFFFFFFFF, 4'h3, 32'h0, 2'b00, 3);
    do_txn("rd8s", 1'b0, 40'h8, 32'h0, 4'h0, 32'hA5A5FFFF, 2'b00, 3);

    // W accepted three cycles before AW
    aw_delay = 3;
    b0 = b_hs; aw0 = aw_hs; w0 = w_hs;
    do_txn("wr_skew", 1'b1, 40'hC, 32'h11223344, 4'hF, 32'h0, 2'b00, 6);
    check("skew_wv_c2", {63'd0, rec_wv[2]}, 64'd0);
    check("skew_awv_c2", {63'd0, rec_awv[2]}, 64'd1);
    check("skew_awv_c4", {63'd0, rec_awv[4]}, 64'd1);
    check("skew_awv_c5", {63'd0, rec_awv[5]}, 64'd0);
    check("skew_hs_counts", {32'(b_hs - b0), 16'(aw_hs - aw0), 16'(w_hs - w0)},
          {32'd1, 16'd1, 16'd1});
    aw_delay = 0;
    do_txn("rd_skew", 1'b0, 40'hC, 32'h0, 4'h0, 32'h11223344, 2'b00, 3);

    // error responses pass through, data unaffected
    rresp_cfg = 2'b10;
    do_txn("rd_slverr", 1'b0, 40'h4, 32'h0, 4'h0, 32'h76543210, 2'b10, 3);
    rresp_cfg = 2'b00;
    bresp_cfg = 2'b11;
    do_txn("wr_decerr", 1'b1, 40'h10, 32'h0BADF00D, 4'hF, 32'h0, 2'b11, 3);
    bresp_cfg = 2'b00;
    do_txn("rd_after_err", 1'b0, 40'h10, 32'h0, 4'h0, 32'h0BADF00D, 2'b00, 3);
    check("timeout_clear", {63'd0, timeout}, 64'd0);

    // watchdog: ARREADY withheld 40 cycles with a 16-cycle limit
    ar_delay = 40;
    do_txn("rd_slow", 1'b0, 40'h0, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 43);
    check("wd_c15", {63'd0, rec_to[15]}, 64'd0);
    check("wd_c16", {63'd0, rec_to[16]}, 64'd1);
    check("wd_arv_c40", {63'd0, rec_arv[40]}, 64'd1);
    check("wd_sticky", {63'd0, timeout}, 64'd1);
    ar_delay = 0;

    // response back-pressure stalls the command stream
    issue_cmd(1'b1, 40'h14, 32'h00000055, 4'hF);
    wait_rsp(lat);
    check("bp_lat", 64'(lat), 64'd3);
    snap_resp = rsp_resp;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 40'h0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready !== 1'b0) bad++;
      if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_resp !== snap_resp ||
          rsp_rdata !== 32'h0 || txn_count !== 32'(exp_txn)) bad++;
      @(negedge clk);
    end
    $display("txn bp: WR addr=0x14 held 10 cycles, stalled-cycle violations=%0d", bad);
    check("bp_stall", 64'(bad), 64'd0);
    cmd_valid = 1'b0;
    consume_rsp("bp");

    // asynchronous reset in the middle of a write
    aw_delay = 10; w_delay = 10;
    issue_cmd(1'b1, 40'h8, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_pre_awv", {63'd0, M_AXI_AWVALID}, 64'd1);
    #1 M_AXI_ARESETN = 1'b0;
    #1;
    check("mid_rst_valids", {62'd0, M_AXI_AWVALID, M_AXI_WVALID}, 64'd0);
    check("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("mid_rst_txn_to", {31'd0, timeout, txn_count}, 64'd0);
    exp_txn = 0;
    aw_delay = 0; w_delay = 0;
    @(negedge clk);
    M_AXI_ARESETN = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {61'd0, cmd_ready, rsp_valid, M_AXI_AWVALID}, 64'd4);
    do_txn("rd_post_rst", 1'b0, 40'h4, 32'h0, 4'h0, 32'h76543210, 2'b00, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
